sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Parametrised N-to-1 arbiter for the CPU's SRAM-like (req/addr_ok/data_ok) bus. It merges NUM_PORTS masters, e.g. the IF-stage fetch port and the EXE/MEM data port, onto one SRAM-like slave such as a bridge or a unified memory. It tracks outstanding transactions in issue order so that each data_ok and its rdata are returned to the master that issued the request. It sits between the pipeline stages and the memory-side bridge, replacing the fixed two-port inst/data split at the CPU top.

## Interface
Parameters:
- NUM_PORTS, 2, number of master ports; port 0 is the highest fixed priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_OUTST, 4, maximum accepted-but-unanswered transactions; must be a power of two and at least 2.
- ARB_MODE, 0, arbitration policy: 0 = fixed priority, 1 = round-robin.

Ports (per-port signals are flattened, port i occupying slice i):
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- m_req  in  NUM_PORTS  master request; held until addr_ok.
- m_wr  in  NUM_PORTS  1 = write.
- m_size  in  2*NUM_PORTS  byte count, encoded as 0→1, 1→2, 2→4 bytes.
- m_wstrb  in  (DATA_W/8)*NUM_PORTS  write byte strobes.
- m_addr  in  ADDR_W*NUM_PORTS  address.
- m_wdata  in  DATA_W*NUM_PORTS  write data.
- m_addr_ok  out  NUM_PORTS  request accepted.
- m_data_ok  out  NUM_PORTS  response for that port.
- m_rdata  out  DATA_W  read data, broadcast to all ports.
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  slave request.
- s_addr_ok, s_data_ok  in  1  slave handshakes.
- s_rdata  in  DATA_W  slave read data.
- outstanding  out  $clog2(MAX_OUTST)+1  current order-FIFO occupancy.
- proto_err  out  1  sticky; set when s_data_ok arrives with no outstanding transaction.

## Operation
- Grant selection:
  - ARB_MODE 0: lowest-indexed requesting port wins.
  - ARB_MODE 1: the first requesting port at or after rr_ptr wins, wrapping modulo NUM_PORTS.
- Grant lock: if s_req is high and s_addr_ok is low, the grant is registered (lock_valid, lock_port). In the following cycles the locked port is forwarded regardless of newer or higher-priority requests. The lock clears on the handshake.
- Slave request: s_req = (any m_req high, or lock_valid) AND outstanding < MAX_OUTST. All s_* request fields are muxed from the granted port. When s_req is low, the request fields are don't-care but are driven from the granted port.
- Address handshake: m_addr_ok[g] = s_addr_ok & s_req. It is never asserted for a non-granted port.
- Issue order: each handshake (s_req & s_addr_ok) pushes g into the order FIFO. In round-robin mode it also sets rr_ptr to (g+1) mod NUM_PORTS.
- Response routing: on s_data_ok with the FIFO non-empty, the head port's m_data_ok is asserted combinationally in the same cycle and the head is popped. m_rdata = s_rdata at all times.
- Empty-FIFO response: s_data_ok with the FIFO empty sets proto_err, asserts no m_data_ok, and leaves the FIFO unchanged.
- Full FIFO: the full check uses the registered count, so no push occurs while full, even if a pop happens in the same cycle. A pop and a push in the same cycle when not full leave the count unchanged.
- Occupancy: outstanding = registered count; the FIFO pointers wrap modulo MAX_OUTST.

## Timing
- Request path is zero-latency: m_req → s_req and s_addr_ok → m_addr_ok are combinational.
- Response path is zero-latency: s_data_ok → m_data_ok is combinational.
- No combinational path from s_addr_ok to s_req.
- Issue-to-count latency: a transaction accepted in cycle t shows in outstanding in cycle t+1 and is eligible for a response from cycle t+1.
- Reset values (resetn low at a clock edge):
  - FIFO empty, outstanding = 0.
  - rr_ptr = 0.
  - lock_valid = 0.
  - proto_err = 0.
  - all m_addr_ok, m_data_ok and s_req low during reset.
- Reset mid-transaction: in-flight transactions are dropped. Any later s_data_ok for them sets proto_err.
- Back-to-back: one handshake per cycle is sustained while the FIFO is not full.

## Structure
- Package cpu_bus_pkg holds:
  - size encodings SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2;
  - ARB_FIXED = 0 and ARB_RR = 1;
  - a function computing the occupancy width.
- Sub-module resp_order_fifo: a synchronous FIFO of MAX_OUTST entries of port index, width $clog2(NUM_PORTS) with a minimum of 1. It exposes push, pop, head, count, full and empty.
- The top level holds the grant logic, the lock register, rr_ptr, the muxes and proto_err.

## Test plan
- Fixed mode, NUM_PORTS=2: both ports request in the same cycle, s_addr_ok=1 → port 0 is granted first, then port 1. Two s_data_ok pulses return to port 0 then port 1, with rdata 0x11111111 and then 0x22222222.
- Lock: port 1 requests alone with s_addr_ok held low for 3 cycles; port 0 raises m_req in cycle 2 → s_addr tracks port 1 until the handshake, and port 0 is served afterwards.
- Round-robin, NUM_PORTS=3: all ports request continuously → grants follow 0, 1, 2, 0, 1, 2; rr_ptr wraps.
- Full: MAX_OUTST=4 with 4 accepted and no data_ok → s_req=0 and outstanding=4. In the same cycle as one data_ok, s_req stays 0; it reasserts the next cycle.
- Error: s_data_ok while empty → proto_err=1 with no m_data_ok. resetn low for one cycle → proto_err=0 and outstanding=0.
- Reset mid-flight: 2 outstanding, then reset → outstanding=0. A subsequent s_data_ok sets proto_err.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU SRAM-like bus: transfer size encodings,
// arbitration policy selectors and width helpers used by the arbiter.
package cpu_bus_pkg;

  // Transfer size encodings carried on the size field (byte count 1/2/4).
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Arbitration policy selectors.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of an occupancy counter that must represent 0..max_outst inclusive.
  function automatic int occ_width(input int max_outst);
    return $clog2(max_outst) + 1;
  endfunction

  // Width of a port index; a single-port build still needs one bit.
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/resp_order_fifo.sv
// Issue-order FIFO of port indices. Each accepted request pushes the index of
// the port that issued it; each response pops the head so the response can be
// routed back to that port.
module resp_order_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_idx_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_o,
  output logic [occ_width(DEPTH)-1:0] count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    if (do_push) mem_q[wr_ptr_q] <= push_idx_i;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-to-1 arbiter for the SRAM-like (req/addr_ok/data_ok) bus. Masters are
// merged onto one slave; an issue-order FIFO routes each data_ok back to the
// master that issued the matching request. A stalled request (s_req high,
// s_addr_ok low) locks the grant so the slave sees a stable request.
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int ARB_MODE  = ARB_FIXED
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS-1:0]            m_req,
  input  logic [NUM_PORTS-1:0]            m_wr,
  input  logic [2*NUM_PORTS-1:0]          m_size,
  input  logic [(DATA_W/8)*NUM_PORTS-1:0] m_wstrb,
  input  logic [ADDR_W*NUM_PORTS-1:0]     m_addr,
  input  logic [DATA_W*NUM_PORTS-1:0]     m_wdata,
  output logic [NUM_PORTS-1:0]            m_addr_ok,
  output logic [NUM_PORTS-1:0]            m_data_ok,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            s_req,
  output logic                            s_wr,
  output logic [1:0]                      s_size,
  output logic [DATA_W/8-1:0]             s_wstrb,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  input  logic                            s_addr_ok,
  input  logic                            s_data_ok,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic [occ_width(MAX_OUTST)-1:0] outstanding,
  output logic                            proto_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_width(NUM_PORTS);
  localparam int OCC_W  = occ_width(MAX_OUTST);

  logic [IDX_W-1:0] grant;
  logic             handshake;
  logic             pop;

  logic             lock_valid_q, lock_valid_d;
  logic [IDX_W-1:0] lock_port_q, lock_port_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             proto_err_q, proto_err_d;

  logic [IDX_W-1:0] fifo_head;
  logic [OCC_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Grant selection: a held lock wins, otherwise fixed priority or round-robin from rr_ptr.
  always_comb begin
    grant = '0;
    if (lock_valid_q) begin
      grant = lock_port_q;
    end else if (ARB_MODE == ARB_RR) begin
      // Scan downwards so the candidate closest to rr_ptr is assigned last.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        int p;
        p = int'(rr_ptr_q) + k;
        if (p >= NUM_PORTS) p = p - NUM_PORTS;
        if (m_req[p]) grant = IDX_W'(p);
      end
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (m_req[p]) grant = IDX_W'(p);
      end
    end
  end

  // Slave request: no path from s_addr_ok, gated by reset and the registered full flag.
  assign s_req     = resetn & ((|m_req) | lock_valid_q) & ~fifo_full;
  assign handshake = s_req & s_addr_ok;
  assign pop       = resetn & s_data_ok & ~fifo_empty;
  assign m_rdata   = s_rdata;
  assign outstanding = fifo_count;
  assign proto_err   = proto_err_q;

  // Request field mux from the granted port, plus per-port handshake decode.
  always_comb begin
    s_wr      = m_wr[0];
    s_size    = m_size[1:0];
    s_wstrb   = m_wstrb[STRB_W-1:0];
    s_addr    = m_addr[ADDR_W-1:0];
    s_wdata   = m_wdata[DATA_W-1:0];
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant == IDX_W'(p)) begin
        s_wr    = m_wr[p];
        s_size  = m_size[2*p +: 2];
        s_wstrb = m_wstrb[STRB_W*p +: STRB_W];
        s_addr  = m_addr[ADDR_W*p +: ADDR_W];
        s_wdata = m_wdata[DATA_W*p +: DATA_W];
      end
      m_addr_ok[p] = handshake & (grant == IDX_W'(p));
      m_data_ok[p] = pop & (fifo_head == IDX_W'(p));
    end
  end

  // Next-state for the grant lock, round-robin pointer and sticky protocol error.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_port_d  = lock_port_q;
    rr_ptr_d     = rr_ptr_q;
    proto_err_d  = proto_err_q | (s_data_ok & fifo_empty);
    if (handshake) begin
      lock_valid_d = 1'b0;
    end else if (s_req) begin
      lock_valid_d = 1'b1;
      lock_port_d  = grant;
    end
    if ((ARB_MODE == ARB_RR) && handshake) begin
      rr_ptr_d = (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + IDX_W'(1);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_port_q  <= '0;
      rr_ptr_q     <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_port_q  <= lock_port_d;
      rr_ptr_q     <= rr_ptr_d;
      proto_err_q  <= proto_err_d;
    end
  end

  resp_order_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_order_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (handshake),
    .push_idx_i (grant),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a fixed-priority 2-port instance and a
// round-robin 3-port instance share clock and reset. A transaction-level model
// (order queue, lock flag, rotating pointer) predicts every output each cycle;
// directed steps add explicit constant expectations for the key scenarios.
module tb_sram_like_arbiter;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Fixed-priority instance, 2 ports
  logic [1:0]  req_f, wr_f, aok_f, dok_f;
  logic [3:0]  size_f;
  logic [7:0]  wstrb_f;
  logic [63:0] addr_f, wdata_f;
  logic        s_req_f, s_wr_f, s_aok_f, s_dok_f, perr_f;
  logic [1:0]  s_size_f;
  logic [3:0]  s_wstrb_f;
  logic [31:0] s_addr_f, s_wdata_f, s_rdata_f, rdata_f;
  logic [2:0]  outst_f;

  // Round-robin instance, 3 ports
  logic [2:0]  req_r, wr_r, aok_r, dok_r;
  logic [5:0]  size_r;
  logic [11:0] wstrb_r;
  logic [95:0] addr_r, wdata_r;
  logic        s_req_r, s_wr_r, s_aok_r, s_dok_r, perr_r;
  logic [1:0]  s_size_r;
  logic [3:0]  s_wstrb_r;
  logic [31:0] s_addr_r, s_wdata_r, s_rdata_r, rdata_r;
  logic [2:0]  outst_r;

  sram_like_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .ARB_MODE(ARB_FIXED)) u_fix (
    .clk(clk), .resetn(resetn),
    .m_req(req_f), .m_wr(wr_f), .m_size(size_f), .m_wstrb(wstrb_f), .m_addr(addr_f), .m_wdata(wdata_f),
    .m_addr_ok(aok_f), .m_data_ok(dok_f), .m_rdata(rdata_f),
    .s_req(s_req_f), .s_wr(s_wr_f), .s_size(s_size_f), .s_wstrb(s_wstrb_f), .s_addr(s_addr_f), .s_wdata(s_wdata_f),
    .s_addr_ok(s_aok_f), .s_data_ok(s_dok_f), .s_rdata(s_rdata_f),
    .outstanding(outst_f), .proto_err(perr_f)
  );

  sram_like_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .resetn(resetn),
    .m_req(req_r), .m_wr(wr_r), .m_size(size_r), .m_wstrb(wstrb_r), .m_addr(addr_r), .m_wdata(wdata_r),
    .m_addr_ok(aok_r), .m_data_ok(dok_r), .m_rdata(rdata_r),
    .s_req(s_req_r), .s_wr(s_wr_r), .s_size(s_size_r), .s_wstrb(s_wstrb_r), .s_addr(s_addr_r), .s_wdata(s_wdata_r),
    .s_addr_ok(s_aok_r), .s_data_ok(s_dok_r), .s_rdata(s_rdata_r),
    .outstanding(outst_r), .proto_err(perr_r)
  );

  // Reference model state, index 0 = fixed instance, 1 = round-robin instance
  int         q0[$];
  int         q1[$];
  bit         lock_v [2] = '{1'b0, 1'b0};
  int         lock_p [2] = '{0, 0};
  int         ptr    [2] = '{0, 0};
  bit         perr   [2] = '{1'b0, 1'b0};
  logic [2:0] exp_aok [2] = '{3'b0, 3'b0};

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int d, input int v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic qclear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // Winner among requesting ports: lowest index (fixed) or first at/after ptr (round-robin)
  function automatic int pick(input int d, input logic [2:0] req);
    int n;
    n = (d == 0) ? 2 : 3;
    for (int k = 0; k < n; k++) begin
      int p;
      p = (d == 0) ? k : (ptr[d] + k) % n;
      if (req[p]) return p;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances with the model, then advance the model past the coming edge
  task automatic sample();
    #2;
    for (int d = 0; d < 2; d++) begin
      logic [2:0]  req_v, wr_v, aok_o, dok_o, e_aok, e_dok;
      logic [5:0]  size_v;
      logic [11:0] wstrb_v;
      logic [95:0] addr_v, wdata_v;
      logic        s_aok_v, s_dok_v, sreq_o, swr_o, perr_o;
      logic [1:0]  ssize_o;
      logic [3:0]  swstrb_o;
      logic [31:0] saddr_o, swdata_o, rdata_o, rdata_in;
      logic [2:0]  outst_o;
      int          cnt, g;
      bit          e_sreq, hs, pop;
      string       pfx;
      if (d == 0) begin
        pfx = "fix";
        req_v = {1'b0, req_f}; wr_v = {1'b0, wr_f}; size_v = {2'b0, size_f}; wstrb_v = {4'b0, wstrb_f};
        addr_v = {32'b0, addr_f}; wdata_v = {32'b0, wdata_f};
        s_aok_v = s_aok_f; s_dok_v = s_dok_f; rdata_in = s_rdata_f;
        aok_o = {1'b0, aok_f}; dok_o = {1'b0, dok_f}; sreq_o = s_req_f; swr_o = s_wr_f; ssize_o = s_size_f;
        swstrb_o = s_wstrb_f; saddr_o = s_addr_f; swdata_o = s_wdata_f; rdata_o = rdata_f;
        outst_o = outst_f; perr_o = perr_f;
      end else begin
        pfx = "rr";
        req_v = req_r; wr_v = wr_r; size_v = size_r; wstrb_v = wstrb_r;
        addr_v = addr_r; wdata_v = wdata_r;
        s_aok_v = s_aok_r; s_dok_v = s_dok_r; rdata_in = s_rdata_r;
        aok_o = aok_r; dok_o = dok_r; sreq_o = s_req_r; swr_o = s_wr_r; ssize_o = s_size_r;
        swstrb_o = s_wstrb_r; saddr_o = s_addr_r; swdata_o = s_wdata_r; rdata_o = rdata_r;
        outst_o = outst_r; perr_o = perr_r;
      end
      cnt    = qsize(d);
      g      = lock_v[d] ? lock_p[d] : pick(d, req_v);
      e_sreq = resetn && ((req_v != 3'b0) || lock_v[d]) && (cnt < 4);
      hs     = e_sreq && s_aok_v;
      pop    = resetn && s_dok_v && (cnt > 0);
      e_aok  = hs ? 3'(1 << g) : 3'b0;
      e_dok  = 3'b0;
      if (pop) e_dok = 3'(1 << qfront(d));

      check($sformatf("%s.s_req", pfx),       32'(sreq_o),  32'(e_sreq));
      check($sformatf("%s.addr_ok", pfx),     32'(aok_o),   32'(e_aok));
      check($sformatf("%s.data_ok", pfx),     32'(dok_o),   32'(e_dok));
      check($sformatf("%s.outstanding", pfx), 32'(outst_o), 32'(cnt));
      check($sformatf("%s.proto_err", pfx),   32'(perr_o),  32'(perr[d]));
      check($sformatf("%s.rdata", pfx),       rdata_o,      rdata_in);
      if (e_sreq) begin
        check($sformatf("%s.s_wr", pfx),    32'(swr_o),    32'(wr_v[g]));
        check($sformatf("%s.s_size", pfx),  32'(ssize_o),  32'(size_v[2*g +: 2]));
        check($sformatf("%s.s_wstrb", pfx), 32'(swstrb_o), 32'(wstrb_v[4*g +: 4]));
        check($sformatf("%s.s_addr", pfx),  saddr_o,       addr_v[32*g +: 32]);
        check($sformatf("%s.s_wdata", pfx), swdata_o,      wdata_v[32*g +: 32]);
      end
      exp_aok[d] = e_aok;

      if (!resetn) begin
        qclear(d);
        lock_v[d] = 1'b0;
        ptr[d]    = 0;
        perr[d]   = 1'b0;
      end else begin
        if (s_dok_v && cnt == 0) perr[d] = 1'b1;
        if (pop) qpop(d);
        if (hs) begin
          qpush(d, g);
          lock_v[d] = 1'b0;
          if (d == 1) ptr[d] = (g + 1) % 3;
        end else if (e_sreq) begin
          lock_v[d] = 1'b1;
          lock_p[d] = g;
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_f = '0; wr_f = 2'b10; size_f = {SZ_HALF, SZ_WORD}; wstrb_f = 8'h3F;
    addr_f = {32'hB000_0100, 32'hA000_0000}; wdata_f = {32'h2222_0000, 32'h1111_0000};
    s_aok_f = 1'b0; s_dok_f = 1'b0; s_rdata_f = 32'h0;
    req_r = '0; wr_r = 3'b101; size_r = {SZ_BYTE, SZ_HALF, SZ_WORD}; wstrb_r = 12'h13F;
    addr_r = {32'hC000_0200, 32'hB000_0100, 32'hA000_0000};
    wdata_r = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    s_aok_r = 1'b0; s_dok_r = 1'b0; s_rdata_r = 32'h0;
  endtask

  function automatic logic [1:0] rand_size();
    case ($urandom_range(0, 2))
      0:       return SZ_BYTE;
      1:       return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  logic [2:0] rr_exp [6];
  logic [1:0] pend_f;
  logic [2:0] pend_r;

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    idle();
    resetn = 1'b0;
    adv();

    // Reset holds requests and handshakes off
    req_f = 2'b11; s_aok_f = 1'b1; req_r = 3'b111; s_aok_r = 1'b1;
    sample();
    check("rst.s_req", 32'(s_req_f), 32'd0);
    check("rst.outstanding", 32'(outst_f), 32'd0);
    check("rst.proto_err", 32'(perr_f), 32'd0);
    adv();

    // Fixed priority: port 0 then port 1, responses in issue order
    resetn = 1'b1; idle();
    req_f = 2'b11; s_aok_f = 1'b1;
    sample(); check("fix.first_grant", 32'(aok_f), 32'b01); adv();
    req_f = 2'b10;
    sample(); check("fix.second_grant", 32'(aok_f), 32'b10); adv();
    req_f = 2'b00; s_aok_f = 1'b0; s_dok_f = 1'b1; s_rdata_f = 32'h1111_1111;
    sample(); check("fix.resp0", 32'(dok_f), 32'b01); check("fix.rdata0", rdata_f, 32'h1111_1111); adv();
    s_rdata_f = 32'h2222_2222;
    sample(); check("fix.resp1", 32'(dok_f), 32'b10); check("fix.rdata1", rdata_f, 32'h2222_2222); adv();
    s_dok_f = 1'b0;

    // Lock: port 1 stalls three cycles, port 0 joins in cycle 2
    req_f = 2'b10;
    sample(); check("lock.c1_addr", s_addr_f, 32'hB000_0100); adv();
    req_f = 2'b11;
    sample(); check("lock.c2_addr", s_addr_f, 32'hB000_0100); adv();
    sample(); check("lock.c3_addr", s_addr_f, 32'hB000_0100); adv();
    s_aok_f = 1'b1;
    sample(); check("lock.handshake", 32'(aok_f), 32'b10); adv();
    req_f = 2'b01;
    sample(); check("lock.port0_after", 32'(aok_f), 32'b01); adv();
    req_f = 2'b00; s_aok_f = 1'b0; s_dok_f = 1'b1;
    sample(); check("lock.resp_port1", 32'(dok_f), 32'b10); adv();
    sample(); check("lock.resp_port0", 32'(dok_f), 32'b01); adv();
    s_dok_f = 1'b0;

    // Full: four accepted, no response
    req_f = 2'b01; s_aok_f = 1'b1;
    repeat (4) begin sample(); adv(); end
    sample(); check("full.s_req", 32'(s_req_f), 32'd0); check("full.outstanding", 32'(outst_f), 32'd4); adv();
    s_dok_f = 1'b1;
    sample(); check("full.pop_same_cycle", 32'(s_req_f), 32'd0); adv();
    s_dok_f = 1'b0;
    sample(); check("full.reassert", 32'(s_req_f), 32'd1); adv();
    req_f = 2'b00; s_aok_f = 1'b0; s_dok_f = 1'b1;
    repeat (4) begin sample(); adv(); end
    s_dok_f = 1'b0;

    // Response with nothing outstanding
    s_dok_f = 1'b1;
    sample(); check("err.no_data_ok", 32'(dok_f), 32'd0); adv();
    s_dok_f = 1'b0;
    sample(); check("err.set", 32'(perr_f), 32'd1); adv();
    sample(); check("err.sticky", 32'(perr_f), 32'd1); adv();
    resetn = 1'b0; sample(); adv();
    resetn = 1'b1;
    sample(); check("err.cleared", 32'(perr_f), 32'd0); check("err.outstanding", 32'(outst_f), 32'd0); adv();

    // Reset with two in flight
    req_f = 2'b11; s_aok_f = 1'b1; sample(); adv();
    req_f = 2'b10; sample(); adv();
    req_f = 2'b00; s_aok_f = 1'b0;
    sample(); check("mid.two_outstanding", 32'(outst_f), 32'd2); adv();
    resetn = 1'b0; sample(); adv();
    resetn = 1'b1;
    sample(); check("mid.dropped", 32'(outst_f), 32'd0); adv();
    s_dok_f = 1'b1;
    sample(); check("mid.no_data_ok", 32'(dok_f), 32'd0); adv();
    s_dok_f = 1'b0;
    sample(); check("mid.proto_err", 32'(perr_f), 32'd1); adv();

    // Round-robin rotation with all three ports requesting
    req_r = 3'b111; s_aok_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_dok_r = (i > 0);
      sample(); check($sformatf("rr.grant%0d", i), 32'(aok_r), 32'(rr_exp[i])); adv();
    end
    req_r = 3'b000; s_aok_r = 1'b0; s_dok_r = 1'b1;
    sample(); adv();
    s_dok_r = 1'b0;

    // Randomized traffic; masters hold a request until it is accepted
    pend_f = '0;
    pend_r = '0;
    for (int i = 0; i < 400; i++) begin
      pend_f = (pend_f & ~exp_aok[0][1:0]) | (2'($urandom) & 2'($urandom));
      pend_r = (pend_r & ~exp_aok[1]) | (3'($urandom) & 3'($urandom));
      req_f = pend_f; wr_f = 2'($urandom); size_f = {rand_size(), rand_size()};
      wstrb_f = 8'($urandom); addr_f = {$urandom, $urandom}; wdata_f = {$urandom, $urandom};
      s_aok_f = 1'($urandom);
      s_dok_f = (qsize(0) > 0) ? 1'($urandom) : ($urandom_range(0, 29) == 0);
      s_rdata_f = $urandom;
      req_r = pend_r; wr_r = 3'($urandom); size_r = {rand_size(), rand_size(), rand_size()};
      wstrb_r = 12'($urandom); addr_r = {$urandom, $urandom, $urandom}; wdata_r = {$urandom, $urandom, $urandom};
      s_aok_r = 1'($urandom);
      s_dok_r = (qsize(1) > 0) ? 1'($urandom) : ($urandom_range(0, 29) == 0);
      s_rdata_r = $urandom;
      resetn = ($urandom_range(0, 99) != 0);
      sample();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
